// File: rtl/mcu_link_pkg.sv
// Shared definitions for the MCU byte-link dispatcher: frame states,
// target index map and the fixed bytes returned to the MCU outside a frame.
package mcu_link_pkg;

    // Frame sequencing states of the dispatcher.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CMD     = 2'd1,
        PAYLOAD = 2'd2,
        DISCARD = 2'd3
    } state_t;

    // Target index map as seen by the MCU in the first byte of a frame.
    localparam int TGT_SYS = 0;
    localparam int TGT_SDC = 1;
    localparam int TGT_HID = 2;
    localparam int TGT_OSD = 3;

    // Bytes returned to the MCU while no target is selected.
    localparam logic [7:0] DOUT_IDLE    = 8'h00;
    localparam logic [7:0] DOUT_DISCARD = 8'hFF;

    // Width of the inactivity counter.
    localparam int TMO_W = 20;

endpackage

// File: rtl/mcu_timeout.sv
// Loadable down-counter guarding an open frame. A load (any MCU byte) always
// wins over expiry; expiry is reported combinationally on the cycle where the
// count sits at 1 with no load, so the caller can react on that same edge.
module mcu_timeout
    import mcu_link_pkg::*;
#(
    parameter logic [TMO_W-1:0] LOAD_VAL = 20'd500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_run,
    output logic o_expire
);

    logic [TMO_W-1:0] r_count;

    // Reload on every MCU byte, otherwise count down while a frame is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_run && (r_count != '0)) begin
            r_count <= r_count - TMO_W'(1);
        end
    end

    assign o_expire = i_run && !i_load && (r_count == TMO_W'(1));

endmodule

// File: rtl/mcu_dispatch.sv
// Front-end arbiter for the MCU byte link. The first byte of each frame picks
// a target; following bytes are forwarded to it as a sysctrl-style stream with
// the command byte flagged, and the selected target's data_out is returned to
// the MCU. Invalid targets are swallowed and stalled frames time out.
module mcu_dispatch
    import mcu_link_pkg::*;
#(
    parameter int               NUM_TARGETS = 4,
    parameter int               SEL_W       = 3,
    parameter logic [TMO_W-1:0] TIMEOUT     = 20'd500000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     mcu_strobe,
    input  logic                     mcu_start,
    input  logic [7:0]               mcu_din,
    output logic [7:0]               mcu_dout,
    output logic [NUM_TARGETS-1:0]   tgt_strobe,
    output logic                     tgt_start,
    output logic [7:0]               tgt_din,
    input  logic [8*NUM_TARGETS-1:0] tgt_dout,
    output logic [SEL_W-1:0]         active_target,
    output logic                     busy,
    output logic                     frame_err
);

    state_t                 r_state;
    state_t                 w_next_state;

    logic [SEL_W-1:0]       r_active_target;
    logic [NUM_TARGETS-1:0] r_tgt_strobe;
    logic                   r_tgt_start;
    logic [7:0]             r_tgt_din;
    logic [7:0]             r_mcu_dout;
    logic                   r_busy;
    logic                   r_frame_err;

    logic                   w_valid_sel;
    logic                   w_run;
    logic                   w_expire;
    logic                   w_fwd;
    logic                   w_fwd_cmd;
    logic                   w_err;
    logic                   w_latch;
    logic [NUM_TARGETS-1:0] w_onehot;
    logic [7:0]             w_sel_dout;
    logic [7:0]             w_dout_next;

    assign w_valid_sel = (mcu_din < 8'(NUM_TARGETS));
    assign w_run       = (r_state != IDLE);

    mcu_timeout #(
        .LOAD_VAL (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_load   (mcu_strobe),
        .i_run    (w_run),
        .o_expire (w_expire)
    );

    // Frame state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and per-byte actions; a start byte outranks everything,
    // any strobe outranks a simultaneous timeout expiry.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        w_fwd        = 1'b0;
        w_fwd_cmd    = 1'b0;
        w_err        = 1'b0;
        w_latch      = 1'b0;
        if (mcu_strobe && mcu_start) begin
            if (w_valid_sel) begin
                w_next_state = CMD;
                w_latch      = 1'b1;
            end else begin
                w_next_state = DISCARD;
                w_err        = 1'b1;
            end
        end else if (mcu_strobe) begin
            case (r_state)
                CMD: begin
                    w_fwd        = 1'b1;
                    w_fwd_cmd    = 1'b1;
                    w_next_state = PAYLOAD;
                end
                PAYLOAD: w_fwd = 1'b1;
                default: ; // IDLE ignores stray bytes, DISCARD swallows them
            endcase
        end else if (w_expire) begin
            w_next_state = IDLE;
            w_err        = 1'b1;
        end
    end

    // Target select decode and the return-data mux.
    always_comb begin
        w_onehot   = '0;
        w_sel_dout = DOUT_IDLE;
        for (int k = 0; k < NUM_TARGETS; k++) begin
            if (r_active_target == SEL_W'(k)) begin
                w_onehot[k] = 1'b1;
                w_sel_dout  = tgt_dout[8*k +: 8];
            end
        end
        case (r_state)
            CMD, PAYLOAD: w_dout_next = w_sel_dout;
            DISCARD:      w_dout_next = DOUT_DISCARD;
            default:      w_dout_next = DOUT_IDLE;
        endcase
    end

    // Registered outputs: forwarded stream, return byte, status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every output register is reset so an abort mid-frame
            // leaves no stale strobe or selection behind.
            r_active_target <= SEL_W'(TGT_SYS);
            r_tgt_strobe    <= '0;
            r_tgt_start     <= 1'b0;
            r_tgt_din       <= 8'h00;
            r_mcu_dout      <= DOUT_IDLE;
            r_busy          <= 1'b0;
            r_frame_err     <= 1'b0;
        end else begin
            if (w_latch) begin
                r_active_target <= mcu_din[SEL_W-1:0];
            end
            r_tgt_strobe <= w_fwd ? w_onehot : '0;
            r_tgt_start  <= w_fwd && w_fwd_cmd;
            if (w_fwd) begin
                r_tgt_din <= mcu_din;
            end
            r_mcu_dout  <= w_dout_next;
            r_busy      <= (w_next_state != IDLE);
            // Back-to-back error events merge into a single pulse.
            r_frame_err <= w_err && !r_frame_err;
        end
    end

    assign mcu_dout      = r_mcu_dout;
    assign tgt_strobe    = r_tgt_strobe;
    assign tgt_start     = r_tgt_start;
    assign tgt_din       = r_tgt_din;
    assign active_target = r_active_target;
    assign busy          = r_busy;
    assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_mcu_dispatch.sv
// Bench for mcu_dispatch: directed frames from the test plan followed by a
// random byte stream, all compared every cycle against a frame-level model.
module tb_mcu_dispatch;
    import mcu_link_pkg::*;

    localparam int         NT  = 4;
    localparam int         SW  = 3;
    localparam logic [19:0] TMO = 20'd16;

    logic            clk        = 1'b0;
    logic            reset_n    = 1'b0;
    logic            mcu_strobe = 1'b0;
    logic            mcu_start  = 1'b0;
    logic [7:0]      mcu_din    = 8'h00;
    logic [7:0]      mcu_dout;
    logic [NT-1:0]   tgt_strobe;
    logic            tgt_start;
    logic [7:0]      tgt_din;
    logic [8*NT-1:0] tgt_dout   = '0;
    logic [SW-1:0]   active_target;
    logic            busy;
    logic            frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_err   = 0;
    int n_strb  = 0;
    int e0, s0;

    logic [NT-1:0] l_strobe;
    logic          l_start;
    logic [7:0]    l_din;

    always #5 clk = ~clk;

    mcu_dispatch #(
        .NUM_TARGETS (NT),
        .SEL_W       (SW),
        .TIMEOUT     (TMO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mcu_strobe    (mcu_strobe),
        .mcu_start     (mcu_start),
        .mcu_din       (mcu_din),
        .mcu_dout      (mcu_dout),
        .tgt_strobe    (tgt_strobe),
        .tgt_start     (tgt_start),
        .tgt_din       (tgt_din),
        .tgt_dout      (tgt_dout),
        .active_target (active_target),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    // Behavioural targets: data_out updates one cycle after their strobe.
    function automatic logic [7:0] resp_of(input int k, input logic [7:0] d);
        return d ^ 8'(17 * (k + 1));
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NT; k++) begin
            if (tgt_strobe[k]) tgt_dout[8*k +: 8] <= resp_of(k, tgt_din);
        end
    end

    // Frame-level reference model.
    int            m_tgt;      // open frame target, -1 when none
    bit            m_discard;  // inside a frame to an invalid target
    bit            m_cmd_next; // next byte of the open frame is the command
    int            m_silence;  // edges since the last byte of an open frame
    int            m_active;
    logic [7:0]    e_dout, e_din;
    logic [NT-1:0] e_strobe;
    logic          e_start, e_busy, e_err;
    logic [SW-1:0] e_active;

    task automatic model_reset();
        m_tgt = -1; m_discard = 0; m_cmd_next = 0; m_silence = 0; m_active = 0;
        e_dout = 8'h00; e_din = 8'h00; e_strobe = '0; e_start = 0;
        e_busy = 0; e_err = 0; e_active = '0;
    endtask

    task automatic model_step(input bit s, input bit st, input logic [7:0] d);
        bit err;
        err = 0;
        e_strobe = '0;
        e_start  = 0;
        if (m_discard)      e_dout = DOUT_DISCARD;
        else if (m_tgt >= 0) e_dout = tgt_dout[8*m_tgt +: 8];
        else                e_dout = DOUT_IDLE;
        if (s && st) begin
            m_silence = 0;
            if (int'(d) < NT) begin
                m_tgt = int'(d); m_active = int'(d); m_cmd_next = 1; m_discard = 0;
            end else begin
                m_tgt = -1; m_discard = 1; err = 1;
            end
        end else if (s) begin
            m_silence = 0;
            if (m_tgt >= 0) begin
                e_strobe[m_tgt] = 1'b1;
                e_start         = m_cmd_next;
                e_din           = d;
                m_cmd_next      = 0;
            end
        end else if (m_tgt >= 0 || m_discard) begin
            m_silence++;
            if (m_silence == int'(TMO)) begin
                m_tgt = -1; m_discard = 0; err = 1;
            end
        end
        e_err    = err && !e_err;
        e_busy   = (m_tgt >= 0) || m_discard;
        e_active = SW'(m_active);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("mcu_dout",      32'(mcu_dout),      32'(e_dout));
        chk("tgt_strobe",    32'(tgt_strobe),    32'(e_strobe));
        chk("tgt_start",     32'(tgt_start),     32'(e_start));
        chk("tgt_din",       32'(tgt_din),       32'(e_din));
        chk("active_target", 32'(active_target), 32'(e_active));
        chk("busy",          32'(busy),          32'(e_busy));
        chk("frame_err",     32'(frame_err),     32'(e_err));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_dout"},   32'(mcu_dout),      32'h00);
        chk({tag, "_strobe"}, 32'(tgt_strobe),    32'h0);
        chk({tag, "_start"},  32'(tgt_start),     32'h0);
        chk({tag, "_din"},    32'(tgt_din),       32'h00);
        chk({tag, "_active"}, 32'(active_target), 32'h0);
        chk({tag, "_busy"},   32'(busy),          32'h0);
        chk({tag, "_err"},    32'(frame_err),     32'h0);
    endtask

    // One clock: drive inputs at the falling edge, check after the next one.
    task automatic cyc(input bit s, input bit st, input logic [7:0] d);
        mcu_strobe = s;
        mcu_start  = st;
        mcu_din    = d;
        model_step(s, st, d);
        @(negedge clk);
        mcu_strobe = 1'b0;
        mcu_start  = 1'b0;
        if (frame_err)   n_err++;
        if (|tgt_strobe) n_strb++;
        l_strobe = tgt_strobe;
        l_start  = tgt_start;
        l_din    = tgt_din;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    // One MCU byte followed by the minimum spacing.
    task automatic send(input bit st, input logic [7:0] d);
        cyc(1'b1, st, d);
        idle(3);
    endtask

    initial begin
        model_reset();
        #1;
        check_reset_values("por");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic routing to the SD card target.
        send(1'b1, 8'(TGT_SDC));
        cyc(1'b1, 1'b0, 8'h04);
        chk("br_cmd_strobe", 32'(l_strobe), 32'b0010);
        chk("br_cmd_start",  32'(l_start),  32'h1);
        chk("br_cmd_din",    32'(l_din),    32'h04);
        idle(3);
        cyc(1'b1, 1'b0, 8'h56);
        chk("br_pl_strobe", 32'(l_strobe), 32'b0010);
        chk("br_pl_start",  32'(l_start),  32'h0);
        idle(3);
        chk("br_rtrip", 32'(mcu_dout), 32'(resp_of(1, 8'h56)));
        send(1'b0, 8'hAA);
        chk("br_active", 32'(active_target), 32'h1);
        chk("br_busy",   32'(busy),          32'h1);

        // Invalid target index: discarded, one error pulse, selection kept.
        e0 = n_err; s0 = n_strb;
        send(1'b1, 8'h07);
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        chk("inv_err_cnt",   32'(n_err - e0),    32'h1);
        chk("inv_no_strobe", 32'(n_strb - s0),   32'h0);
        chk("inv_dout",      32'(mcu_dout),      32'hFF);
        chk("inv_active",    32'(active_target), 32'h1);

        // A new start byte aborts the open frame without an error.
        send(1'b1, 8'(TGT_SYS));
        send(1'b0, 8'h31);
        send(1'b0, 8'h32);
        e0 = n_err;
        cyc(1'b1, 1'b1, 8'(TGT_HID));
        chk("ab_start_no_strobe", 32'(l_strobe), 32'h0);
        idle(3);
        cyc(1'b1, 1'b0, 8'h03);
        chk("ab_strobe", 32'(l_strobe), 32'b0100);
        chk("ab_start",  32'(l_start),  32'h1);
        chk("ab_din",    32'(l_din),    32'h03);
        idle(3);
        chk("ab_no_err", 32'(n_err - e0), 32'h0);

        // Timeout after a start byte followed by silence.
        e0 = n_err;
        cyc(1'b1, 1'b1, 8'h00);
        idle(15);
        chk("tmo_busy_held", 32'(busy), 32'h1);
        idle(1);
        chk("tmo_busy_fell", 32'(busy), 32'h0);
        idle(3);
        chk("tmo_err_cnt", 32'(n_err - e0), 32'h1);
        cyc(1'b1, 1'b0, 8'h33);
        chk("tmo_no_strobe", 32'(l_strobe), 32'h0);
        idle(3);

        // Payload byte landing exactly on the expiry edge.
        send(1'b1, 8'h00);
        cyc(1'b1, 1'b0, 8'h10);
        idle(15);
        e0 = n_err;
        cyc(1'b1, 1'b0, 8'h20);
        chk("tie_strobe", 32'(l_strobe), 32'b0001);
        chk("tie_din",    32'(l_din),    32'h20);
        idle(3);
        chk("tie_busy",   32'(busy),        32'h1);
        chk("tie_no_err", 32'(n_err - e0),  32'h0);

        // Asynchronous reset between two payload bytes.
        send(1'b0, 8'h40);
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 1'b0, 8'h41);
        chk("rst_ignored", 32'(l_strobe), 32'h0);
        idle(3);
        chk("rst_idle", 32'(busy), 32'h0);

        // A frame to the OSD target.
        send(1'b1, 8'(TGT_OSD));
        cyc(1'b1, 1'b0, 8'h5A);
        chk("osd_strobe", 32'(l_strobe), 32'b1000);
        idle(3);

        // Random byte stream with gaps that sometimes exceed the timeout.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 3) cyc(1'b1, 1'b1, 8'($urandom_range(0, 5)));
            else                          cyc(1'b1, 1'b0, 8'($urandom()));
            idle(int'($urandom_range(3, 20)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
